// File: rtl/pipe_pkg.sv
// Shared types and constants for the in-order issue controller.
package pipe_pkg;

    localparam int REG_W  = 4;
    localparam int ADDR_W = 8;

    localparam logic [1:0] FUNC_ADD = 2'd0;
    localparam logic [1:0] FUNC_SUB = 2'd1;
    localparam logic [1:0] FUNC_AND = 2'd2;
    localparam logic [1:0] FUNC_XOR = 2'd3;

    // One buffered instruction word (22 bits).
    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [1:0]        func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

endpackage

// File: rtl/pipe_issue_ctrl_fifo.sv
// Instruction FIFO: DEPTH entries of instr_t with occupancy count.
// Pushes when full and pops when empty are ignored; flush clears it.
module instr_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  instr_t                     wdata,
    output instr_t                     rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    instr_t           mem_q [DEPTH];
    instr_t           mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    // Next pointers, count and storage from the accepted push/pop.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q] = wdata;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state: pointers and count, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage: data only, no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: FIFO-buffered instructions, per-register
// countdown scoreboard for RAW hazards, one issue per cycle, and a
// saturating counter of hazard-stall cycles.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 2,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [1:0]        in_func,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              run,
    input  logic              flush,
    output logic              iss_valid,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2,
    output logic [REG_W-1:0]  iss_rd,
    output logic [1:0]        iss_func,
    output logic [ADDR_W-1:0] iss_addr,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    localparam logic [1:0] WB_LAT_C = 2'(WB_LAT);

    instr_t                  in_word;
    instr_t                  head;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    hazard;
    logic                    issue;
    logic                    stall;
    logic [NREG-1:0]         pend;

    logic [1:0]  cnt_q [NREG];
    logic [1:0]  cnt_d [NREG];
    logic        iss_valid_q, iss_valid_d;
    instr_t      iss_q, iss_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign in_word  = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    assign in_ready = ~fifo_full & ~flush;
    assign push     = in_valid & in_ready;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (issue),
        .wdata (in_word),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Hazard check on the FIFO head and issue/stall decision for this edge.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend[r] = (cnt_q[r] != 2'd0);
        end
        hazard = pend[head.rs1] | pend[head.rs2];
        issue  = ~fifo_empty & run & ~hazard & ~flush;
        stall  = ~fifo_empty & run &  hazard & ~flush;
        busy   = ~fifo_empty | (|pend);
    end

    // Scoreboard reload on issue (wins over countdown), issue regs, stall count.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && (head.rd == REG_W'(r))) begin
                cnt_d[r] = WB_LAT_C;
            end else if (cnt_q[r] != 2'd0) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
        iss_valid_d = issue;
        iss_d       = issue ? head : iss_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers; reset discards in-flight scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= 2'd0;
            end
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            stall_cnt_q <= 16'd0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            iss_valid_q <= iss_valid_d;
            iss_q       <= iss_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_rs1   = iss_q.rs1;
    assign iss_rs2   = iss_q.rs2;
    assign iss_rd    = iss_q.rd;
    assign iss_func  = iss_q.func;
    assign iss_addr  = iss_q.addr;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios plus random traffic,
// checked each cycle against a timestamp-based reference model.
module tb_pipe_issue_ctrl;
    import pipe_pkg::*;

    localparam int DEPTH  = 4;
    localparam int WB_LAT = 2;
    localparam int NREG   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_rs1, in_rs2, in_rd;
    logic [1:0]        in_func;
    logic [ADDR_W-1:0] in_addr;
    logic              run;
    logic              flush;
    logic              iss_valid;
    logic [REG_W-1:0]  iss_rs1, iss_rs2, iss_rd;
    logic [1:0]        iss_func;
    logic [ADDR_W-1:0] iss_addr;
    logic              busy;
    logic [15:0]       stall_cnt;

    pipe_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT), .NREG(NREG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func),
        .in_addr(in_addr), .run(run), .flush(flush), .iss_valid(iss_valid),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_addr(iss_addr), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of pending words; rdy[r] is the first edge
    // number at which register r may be read by an issuing instruction.
    instr_t q[$];
    int     rdy [NREG];
    int     e = 0;
    instr_t exp_iss;
    logic   exp_valid;
    int     exp_stall;
    int     iss_edges[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int f, input int a);
        instr_t w;
        w.rs1  = 4'(rs1);
        w.rs2  = 4'(rs2);
        w.rd   = 4'(rd);
        w.func = 2'(f);
        w.addr = 8'(a);
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < NREG; r++) rdy[r] = 0;
        exp_iss   = '0;
        exp_valid = 1'b0;
        exp_stall = 0;
    endtask

    // One clock: drive inputs, check in_ready, advance model and DUT, compare.
    task automatic step(input logic v, input instr_t w, input logic r, input logic fl);
        instr_t hd;
        bit ne, hz, do_iss, do_stall, do_push, bz;
        in_valid = v;
        in_rs1 = w.rs1; in_rs2 = w.rs2; in_rd = w.rd;
        in_func = w.func; in_addr = w.addr;
        run = r; flush = fl;
        #1;
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH && !fl));
        ne       = (q.size() != 0);
        hd       = ne ? q[0] : '0;
        hz       = ne && ((e < rdy[int'(hd.rs1)]) || (e < rdy[int'(hd.rs2)]));
        do_iss   = ne && r && !hz && !fl;
        do_stall = ne && r && hz && !fl;
        do_push  = v && (q.size() < DEPTH) && !fl;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        if (do_iss) begin
            q.delete(0);
            exp_iss = hd;
            rdy[int'(hd.rd)] = e + WB_LAT + 1;
        end
        if (do_push) q.push_back(w);
        exp_valid = do_iss;
        if (do_stall && exp_stall != 65535) exp_stall++;
        bz = (q.size() != 0);
        for (int k = 0; k < NREG; k++) if (rdy[k] > e + 1) bz = 1;
        if (iss_valid === 1'b1) iss_edges.push_back(e);
        e++;
        chk("iss_valid", 32'(iss_valid), 32'(exp_valid));
        chk("iss_rs1",   32'(iss_rs1),   32'(exp_iss.rs1));
        chk("iss_rs2",   32'(iss_rs2),   32'(exp_iss.rs2));
        chk("iss_rd",    32'(iss_rd),    32'(exp_iss.rd));
        chk("iss_func",  32'(iss_func),  32'(exp_iss.func));
        chk("iss_addr",  32'(iss_addr),  32'(exp_iss.addr));
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        chk("busy",      32'(busy),      32'(bz));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_iss_rd",    32'(iss_rd),    32'd0);
        in_valid = 1'b0; run = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        iss_edges.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; run = 1'b0; flush = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_func = '0; in_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_in_ready",  32'(in_ready),  32'd1);
        chk("init_iss_valid", 32'(iss_valid), 32'd0);
        chk("init_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("init_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;

        // Three independent instructions issue back to back.
        step(1'b1, mk(5, 3, 1, FUNC_ADD, 125), 1'b1, 1'b0);
        step(1'b1, mk(6, 4, 2, FUNC_SUB, 126), 1'b1, 1'b0);
        step(1'b1, mk(7, 5, 3, FUNC_ADD, 127), 1'b1, 1'b0);
        idle(6);
        chk("t1_issues", 32'(iss_edges.size()), 32'd3);
        if (iss_edges.size() == 3) chk("t1_consec", 32'(iss_edges[2] - iss_edges[0]), 32'd2);
        chk("t1_stall", 32'(stall_cnt), 32'd0);

        // Dependent pair: issue distance WB_LAT+1, two stall cycles.
        do_reset();
        step(1'b1, mk(5, 3, 1, FUNC_ADD, 1), 1'b1, 1'b0);
        step(1'b1, mk(1, 6, 4, FUNC_XOR, 2), 1'b1, 1'b0);
        idle(6);
        chk("t2_issues", 32'(iss_edges.size()), 32'd2);
        if (iss_edges.size() == 2) chk("t2_gap", 32'(iss_edges[1] - iss_edges[0]), 32'd3);
        chk("t2_stall", 32'(stall_cnt), 32'd2);

        // Fill with run low; fifth word refused; then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, mk(8 + i, 9, 10 + i, i % 4, 40 + i), 1'b0, 1'b0);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        idle(8);
        chk("t3_issues", 32'(iss_edges.size()), 32'd4);
        chk("t3_last_addr", 32'(iss_addr), 32'd43);

        // Flush one edge after issuing rd=2 with three words queued.
        do_reset();
        step(1'b1, mk(0, 0, 2, FUNC_AND, 7), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(2, 2, 5, FUNC_ADD, 8 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("t4_busy_pending", 32'(busy), 32'd1);
        idle(3);
        chk("t4_issues", 32'(iss_edges.size()), 32'd1);

        // Chain of three dependent instructions.
        do_reset();
        step(1'b1, mk(4, 4, 1, FUNC_ADD, 1), 1'b1, 1'b0);
        step(1'b1, mk(1, 0, 2, FUNC_SUB, 2), 1'b1, 1'b0);
        step(1'b1, mk(0, 2, 3, FUNC_XOR, 3), 1'b1, 1'b0);
        idle(10);
        chk("t5_issues", 32'(iss_edges.size()), 32'd3);
        if (iss_edges.size() == 3) begin
            chk("t5_gap1", 32'(iss_edges[1] - iss_edges[0]), 32'd3);
            chk("t5_gap2", 32'(iss_edges[2] - iss_edges[1]), 32'd3);
        end
        chk("t5_stall", 32'(stall_cnt), 32'd4);

        // Self-dependence does not stall.
        step(1'b1, mk(9, 9, 9, FUNC_ADD, 9), 1'b1, 1'b0);
        idle(2);

        // Random traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 255)),
                 1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 29) == 0));
        end

        // Reset in the middle of a hazard stall.
        do_reset();
        step(1'b1, mk(0, 0, 5, FUNC_ADD, 1), 1'b1, 1'b0);
        step(1'b1, mk(5, 0, 6, FUNC_ADD, 2), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t6_pre_stall", 32'(stall_cnt), 32'd1);
        do_reset();
        idle(3);
        chk("t6_no_issue", 32'(iss_edges.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
